// File: rtl/sobel_stream_pkg.sv
// Shared types and helpers for the Sobel stream ingress shell.
// Contents:
//   state_e      control FSM states
//   Def*         default geometry and stage latency
//   cnt_width()  counter width that holds values 0..n-1
package sobel_stream_pkg;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, CLEAR} state_e;

    localparam int unsigned DefPixelsPerBeat = 16;
    localparam int unsigned DefImageDim      = 512;
    localparam int unsigned DefPipeLat       = 24;
    localparam int unsigned DefCm            = DefImageDim / DefPixelsPerBeat;
    localparam int unsigned DefNb            = DefImageDim * DefCm;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sobel_valid_tag.sv
// DEPTH-deep 1-bit shift register with enable. Travels alongside the Sobel stage
// so each stage output carries a bit saying whether it is a real output beat.
// Ports:
//   clk     clock
//   areset  synchronous active-high reset (clears all bits)
//   en      shift enable (stage advance)
//   d       tag for the beat entering the stage
//   q       tag for the beat leaving the stage
module sobel_valid_tag #(
    parameter int unsigned DEPTH = 24
) (
    input  logic clk,
    input  logic areset,
    input  logic en,
    input  logic d,
    output logic q
);

    logic [DEPTH-1:0] sr_q;

    always_ff @(posedge clk) begin
        if (areset) begin
            sr_q <= '0;
        end else if (en) begin
            sr_q[0] <= d;
            for (int i = 1; i < int'(DEPTH); i++) begin
                sr_q[i] <= sr_q[i-1];
            end
        end
    end

    assign q = sr_q[DEPTH-1];

endmodule

// File: rtl/sobel_stream_ingress.sv
// Flow-control shell around the Sobel line-buffer/CORDIC stage.
// Converts AXI-Stream handshakes on both sides into the single global stage stall,
// injects zero flush beats so the last row and the pipeline tail drain, and tags
// stage outputs so exactly one output beat leaves per input beat.
// Optional feature: define SOBEL_LEN_CHECK_EN to enable framing checks (err_len).
// Ports:
//   clk, areset                      clock, synchronous active-high reset
//   s_axis_t{data,valid,ready,user,last}  image source side
//   conv_frame, conv_stall, conv_aresetn  drive to Sobel stage
//   conv_out                         Sobel stage output
//   m_axis_t{data,valid,ready,user,last}  edge-map sink side
//   err_len                          sticky framing error
module sobel_stream_ingress
    import sobel_stream_pkg::*;
#(
    parameter int unsigned PIXELS_PER_BEAT = DefPixelsPerBeat,
    parameter int unsigned IMAGE_DIM       = DefImageDim,
    parameter int unsigned DATA_WIDTH      = 8 * PIXELS_PER_BEAT,
    parameter int unsigned PIPE_LAT        = DefPipeLat
) (
    input  logic                  clk,
    input  logic                  areset,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tuser,
    input  logic                  s_axis_tlast,
    output logic [DATA_WIDTH-1:0] conv_frame,
    output logic                  conv_stall,
    output logic                  conv_aresetn,
    input  logic [DATA_WIDTH-1:0] conv_out,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tuser,
    output logic                  m_axis_tlast,
    output logic                  err_len
);

    localparam int unsigned CM      = IMAGE_DIM / PIXELS_PER_BEAT;
    localparam int unsigned NB      = IMAGE_DIM * CM;
    localparam int unsigned LastIdx = NB + CM + PIPE_LAT - 1;
    localparam int unsigned IdxW    = cnt_width(LastIdx + 1);
    localparam int unsigned OutW    = cnt_width(NB);

    localparam logic [IdxW-1:0] TagLo     = IdxW'(CM);
    localparam logic [IdxW-1:0] TagHi     = IdxW'(CM + NB - 1);
    localparam logic [IdxW-1:0] RunLast   = IdxW'(NB - 1);
    localparam logic [IdxW-1:0] FlushLast = IdxW'(LastIdx);
    localparam logic [OutW-1:0] OutLast   = OutW'(NB - 1);

    state_e          state_q, state_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic [OutW-1:0] ocnt_q, ocnt_d;
    logic            sent_q, sent_d;
    logic            tag_out, tag_in;
    logic            out_ok, src_ok, adv, m_hs, run_last;
    logic            err_set;

    sobel_valid_tag #(
        .DEPTH (PIPE_LAT)
    ) u_tag (
        .clk    (clk),
        .areset (areset),
        .en     (adv),
        .d      (tag_in),
        .q      (tag_out)
    );

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        s_axis_tready = 1'b0;
        conv_frame    = '0;
        conv_aresetn  = 1'b1;
        err_set       = 1'b0;

        // A tagged beat already taken by the sink while the stage could not advance
        // must not be offered again, so sent_q masks it until the next advance.
        m_axis_tvalid = tag_out & ~sent_q;
        m_hs          = m_axis_tvalid & m_axis_tready;
        out_ok        = ~tag_out | sent_q | m_axis_tready;
        src_ok        = ((state_q == RUN) & s_axis_tvalid) | (state_q == FLUSH);
        adv           = out_ok & src_ok;
        tag_in        = (idx_q >= TagLo) && (idx_q <= TagHi);
        run_last      = (idx_q == RunLast);

        unique case (state_q)
            IDLE: begin
                // The SOF beat is left pending so RUN takes it as beat 0.
                s_axis_tready = ~s_axis_tuser;
                if (s_axis_tvalid && s_axis_tuser) begin
                    state_d = RUN;
                    idx_d   = '0;
                end
            end
            RUN: begin
                s_axis_tready = out_ok;
                conv_frame    = s_axis_tdata;
                if (adv) begin
                    idx_d = idx_q + 1'b1;
`ifdef SOBEL_LEN_CHECK_EN
                    err_set = (s_axis_tuser && (idx_q != '0)) || (s_axis_tlast != run_last);
                    if (run_last || s_axis_tlast) begin
                        state_d = FLUSH;
                    end
`else
                    if (run_last) begin
                        state_d = FLUSH;
                    end
`endif
                end
            end
            FLUSH: begin
                if (adv) begin
                    idx_d = idx_q + 1'b1;
                    if (idx_q == FlushLast) begin
                        state_d = CLEAR;
                    end
                end
            end
            CLEAR: begin
                conv_aresetn = 1'b0;
                state_d      = IDLE;
            end
            default: state_d = CLEAR;
        endcase

        conv_stall = ~adv;

        ocnt_d = ocnt_q;
        if (m_hs) begin
            ocnt_d = (ocnt_q == OutLast) ? '0 : ocnt_q + 1'b1;
        end
        sent_d = adv ? 1'b0 : (m_hs | sent_q);

        m_axis_tdata = conv_out;
        m_axis_tuser = m_axis_tvalid & (ocnt_q == '0);
        m_axis_tlast = m_axis_tvalid & (ocnt_q == OutLast);
    end

    always_ff @(posedge clk) begin
        if (areset) begin
            state_q <= CLEAR;
            idx_q   <= '0;
            ocnt_q  <= '0;
            sent_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ocnt_q  <= ocnt_d;
            sent_q  <= sent_d;
        end
    end

`ifdef SOBEL_LEN_CHECK_EN
    logic err_q;

    always_ff @(posedge clk) begin
        if (areset) begin
            err_q <= 1'b0;
        end else if (err_set) begin
            err_q <= 1'b1;
        end
    end

    assign err_len = err_q;
`else
    logic unused_framing;
    assign unused_framing = s_axis_tlast ^ err_set;
    assign err_len        = 1'b0;
`endif

endmodule

// File: tb/tb_sobel_stream_ingress.sv
module tb_sobel_stream_ingress;

    localparam int PPB = 16;
    localparam int DIM = 64;
    localparam int PL  = 6;
    localparam int DW  = 8 * PPB;
    localparam int CM  = DIM / PPB;
    localparam int NB  = DIM * CM;

    logic          clk = 1'b0;
    logic          areset;
    logic [DW-1:0] s_axis_tdata;
    logic          s_axis_tvalid, s_axis_tready, s_axis_tuser, s_axis_tlast;
    logic [DW-1:0] conv_frame, conv_out, m_axis_tdata;
    logic          conv_stall, conv_aresetn;
    logic          m_axis_tvalid, m_axis_tready, m_axis_tuser, m_axis_tlast;
    logic          err_len;

    always #5 clk = ~clk;

    sobel_stream_ingress #(
        .PIXELS_PER_BEAT (PPB),
        .IMAGE_DIM       (DIM),
        .DATA_WIDTH      (DW),
        .PIPE_LAT        (PL)
    ) dut (
        .clk           (clk),
        .areset        (areset),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tlast  (s_axis_tlast),
        .conv_frame    (conv_frame),
        .conv_stall    (conv_stall),
        .conv_aresetn  (conv_aresetn),
        .conv_out      (conv_out),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tlast  (m_axis_tlast),
        .err_len       (err_len)
    );

    // Behavioural stand-in for the Sobel stage: vertical gradient |below - above| per
    // pixel, centre beat CM behind the input, PL stages of latency, frozen on stall.
    logic [DW-1:0] hist [2*CM];
    logic [DW-1:0] pipe [PL];

    function automatic logic [DW-1:0] grad(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [DW-1:0] r;
        logic [7:0]    pa, pb;
        for (int p = 0; p < PPB; p++) begin
            pa = a[p*8 +: 8];
            pb = b[p*8 +: 8];
            r[p*8 +: 8] = (pa > pb) ? pa - pb : pb - pa;
        end
        return r;
    endfunction

    always @(posedge clk) begin
        if (!conv_aresetn) begin
            for (int i = 0; i < 2*CM; i++) hist[i] <= '0;
            for (int i = 0; i < PL; i++) pipe[i] <= '0;
        end else if (!conv_stall) begin
            pipe[0] <= grad(conv_frame, hist[2*CM-1]);
            for (int i = 1; i < PL; i++) pipe[i] <= pipe[i-1];
            hist[0] <= conv_frame;
            for (int i = 1; i < 2*CM; i++) hist[i] <= hist[i-1];
        end
    end
    assign conv_out = pipe[PL-1];

    // Stimulus / capture state
    logic [DW-1:0] frm [2][NB];
    logic [DW+1:0] src_q [600];
    logic [DW+1:0] out_q [600];
    int src_len = 0, src_ptr = 0, src_pct = 100, snk_pct = 100;
    bit snk_hold = 1'b0;
    int out_n = 0;
    int cyc = 0, last_in_cyc = 0, clr_cyc = 0, lo_cnt = 0, sof_gap = -1;
    int n_chk = 0, n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [DW+1:0] got,
                            input logic [DW+1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Source: holds tvalid and data until accepted.
    initial begin
        bit hs;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tuser  = 1'b0;
        s_axis_tlast  = 1'b0;
        forever begin
            @(negedge clk);
            hs = s_axis_tvalid & s_axis_tready;
            if (!conv_aresetn) begin
                clr_cyc = cyc;
                lo_cnt++;
            end
            if (hs) begin
                last_in_cyc = cyc;
                if (s_axis_tuser) sof_gap = cyc - clr_cyc;
            end
            @(posedge clk);
            #1;
            if (hs) src_ptr++;
            if (src_ptr < src_len) begin
                if (!s_axis_tvalid || hs) s_axis_tvalid = ($urandom_range(99) < src_pct);
                {s_axis_tuser, s_axis_tlast, s_axis_tdata} = src_q[src_ptr];
            end else begin
                s_axis_tvalid = 1'b0;
            end
        end
    end

    // Sink: random ready, captures every handshake.
    initial begin
        m_axis_tready = 1'b0;
        forever begin
            @(negedge clk);
            if (m_axis_tvalid && m_axis_tready && out_n < 600) begin
                out_q[out_n] = {m_axis_tuser, m_axis_tlast, m_axis_tdata};
                out_n++;
            end
            @(posedge clk);
            #1;
            m_axis_tready = !snk_hold && ($urandom_range(99) < snk_pct);
        end
    end

    task automatic make_frame(input int f, input int kind);
        for (int b = 0; b < NB; b++)
            for (int p = 0; p < PPB; p++)
                frm[f][b][p*8 +: 8] = (kind == 0) ? 8'(b * 7 + p * 13) : 8'($urandom);
    endtask

    task automatic src_clear();
        @(posedge clk);
        #2;
        src_len       = 0;
        src_ptr       = 0;
        out_n         = 0;
        s_axis_tvalid = 1'b0;
    endtask

    task automatic load_src(input int f, input int garbage, input int tlast_at);
        for (int g = 0; g < garbage; g++) src_q[src_len++] = {2'b00, 64'($urandom), 64'($urandom)};
        for (int b = 0; b <= tlast_at; b++)
            src_q[src_len++] = {(b == 0), (b == tlast_at), frm[f][b]};
    endtask

    function automatic logic [DW-1:0] xbeat(input int f, input int j, input int cut);
        if (j < 0 || j >= NB || j > cut) return '0;
        return frm[f][j];
    endfunction

    task automatic check_frame(input string tag, input int f, input int base, input int cut);
        logic [DW+1:0] exp;
        for (int k = 0; k < NB; k++) begin
            exp = {(k == 0), (k == NB - 1), grad(xbeat(f, k + CM, cut), xbeat(f, k - CM, cut))};
            check_eq($sformatf("%s[%0d]", tag, k), out_q[base + k], exp);
        end
    endtask

    task automatic wait_out(input string tag, input int n, input int budget);
        int c = 0;
        while (out_n < n && c < budget) begin
            @(posedge clk);
            c++;
        end
        repeat (40) @(posedge clk);
        check_eq({tag, "_count"}, out_n, n);
    endtask

    task automatic check_reset_outputs(input string tag);
        @(negedge clk);
        check_eq({tag, "_s_tready"}, s_axis_tready, 0);
        check_eq({tag, "_m_tvalid"}, m_axis_tvalid, 0);
        check_eq({tag, "_m_tuser"}, m_axis_tuser, 0);
        check_eq({tag, "_m_tlast"}, m_axis_tlast, 0);
        check_eq({tag, "_stall"}, conv_stall, 1);
        check_eq({tag, "_aresetn"}, conv_aresetn, 0);
        check_eq({tag, "_frame"}, conv_frame, 0);
        check_eq({tag, "_err"}, err_len, 0);
    endtask

    initial begin
        int lo0, c;
        logic [DW-1:0] held;

        areset = 1'b1;
        repeat (3) @(posedge clk);
        check_reset_outputs("rst");
        @(posedge clk);
        #1 areset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_eq("idle_ready", s_axis_tready, 1);

        // 1: full rate, ramp frame
        make_frame(0, 0);
        src_pct = 100; snk_pct = 100;
        src_clear();
        lo0 = lo_cnt;
        load_src(0, 0, NB - 1);
        wait_out("t1", NB, 2000);
        check_frame("t1", 0, 0, NB);
        check_eq("t1_flush_len", clr_cyc - last_in_cyc, 11);
        check_eq("t1_clear_cycles", lo_cnt - lo0, 1);

        // 2: sink stalls 20 cycles mid-frame
        make_frame(1, 1);
        src_clear();
        load_src(1, 0, NB - 1);
        c = 0;
        while (out_n < 50 && c < 2000) begin
            @(posedge clk);
            c++;
        end
        snk_hold = 1'b1;
        held = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check_eq($sformatf("t2_stall[%0d]", i), conv_stall, 1);
            if (i == 0) held = m_axis_tdata;
            else check_eq($sformatf("t2_hold[%0d]", i), m_axis_tdata, held);
        end
        snk_hold = 1'b0;
        wait_out("t2", NB, 2000);
        check_frame("t2", 1, 0, NB);

        // 3: random source and sink
        make_frame(0, 1);
        src_pct = 50; snk_pct = 30;
        src_clear();
        load_src(0, 0, NB - 1);
        wait_out("t3", NB, 8000);
        check_frame("t3", 0, 0, NB);

        // 4: garbage before SOF
        src_pct = 100; snk_pct = 100;
        src_clear();
        load_src(1, 3, NB - 1);
        wait_out("t4", NB, 2000);
        check_frame("t4", 1, 0, NB);
        check_eq("t4_drained", src_ptr, src_len);

        // 5: back-to-back frames
        make_frame(0, 1);
        make_frame(1, 0);
        src_clear();
        load_src(0, 0, NB - 1);
        load_src(1, 0, NB - 1);
        wait_out("t5", 2 * NB, 4000);
        check_frame("t5a", 0, 0, NB);
        check_frame("t5b", 1, NB, NB);
        check_eq("t5_sof_gap", sof_gap, 2);

`ifdef SOBEL_LEN_CHECK_EN
        // 6: early tlast at beat 100
        make_frame(0, 1);
        src_clear();
        load_src(0, 0, 100);
        wait_out("t6", NB, 3000);
        check_frame("t6", 0, 0, 100);
        check_eq("t6_err", err_len, 1);
`endif

        // 7: reset mid-frame, then a clean frame
        make_frame(1, 1);
        src_clear();
        load_src(1, 0, NB - 1);
        c = 0;
        while (out_n < 30 && c < 2000) begin
            @(posedge clk);
            c++;
        end
        #1 areset = 1'b1;
        @(posedge clk);
        check_reset_outputs("t7_rst");
        src_clear();
        areset = 1'b0;
        load_src(1, 0, NB - 1);
        wait_out("t7", NB, 2000);
        check_frame("t7", 1, 0, NB);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
